// File: rtl/sb_axi_arbiter.sv
// sb_axi_arbiter: lets NUM_REQ stream-buffer prefetchers take turns on one
// AXI read port (AR + R). Grants rotate round-robin, and only one burst is in
// flight at a time. The winner's AR fields are latched and driven to memory.
// R beats are then steered back to the winner until RLAST.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   req_arvalid/araddr/arlen      per-requester AR request (flattened vectors)
//   req_arready                   one-hot accept pulse
//   req_rvalid                    one-hot beat valid (granted requester only)
//   req_rdata/req_rlast           beat data/last, broadcast
//   req_rready                    per-requester beat ready
//   mem_ar*                       AR master toward memory
//   mem_r*                        R master from memory
//   busy                          arbiter is not idle
//   grant_idx                     current/last granted requester
//   err                           sticky protocol error
//
// state | meaning
// IDLE  | no burst in flight, picking the next winner
// ADDR  | driving the latched AR toward memory
// DATA  | forwarding R beats to the winner until RLAST

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sb_axi_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `ADDR_WIDTH,
  parameter int DATA_W  = `DATA_WIDTH,
  parameter int LEN_W   = 8,
  parameter int ID_BASE = 0,
  parameter int ID_W    = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_rlast,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic                      mem_arvalid,
  input  logic                      mem_arready,
  output logic [ADDR_W-1:0]         mem_araddr,
  output logic [LEN_W-1:0]          mem_arlen,
  output logic [ID_W-1:0]           mem_arid,
  input  logic                      mem_rvalid,
  output logic                      mem_rready,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rlast,
  input  logic [ID_W-1:0]           mem_rid,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [LEN_W-1:0]  ar_len_q;
  logic [ID_W-1:0]   ar_id_q;
  logic [LEN_W:0]    beat_cnt;
  logic              r_hs;
  logic              proto_err;

  // (base + off) mod NUM_REQ, for off < NUM_REQ; works for non-power-of-two counts
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest set index after rr_ptr wins
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_arvalid[wrap_add(rr_ptr, i)]) begin
        winner  = wrap_add(rr_ptr, i);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_arready = '0;
    req_rvalid  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_arready[winner] = 1'b1;
          state_nxt           = ADDR;
        end
      end
      ADDR: begin
        mem_arvalid = 1'b1;
        if (mem_arready) state_nxt = DATA;
      end
      DATA: begin
        mem_rready            = req_rready[grant_idx];
        req_rvalid[grant_idx] = mem_rvalid;
        if (mem_rvalid && req_rready[grant_idx] && mem_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, even if the FSM was mid-burst
    if (rst) begin
      req_arready = '0;
      req_rvalid  = '0;
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      state_nxt   = IDLE;
    end
  end

  assign r_hs = (state == DATA) && mem_rvalid && req_rready[grant_idx];

  assign proto_err = (mem_rid != ar_id_q)
                  || ( mem_rlast && (beat_cnt != {1'b0, ar_len_q}))
                  || (!mem_rlast && (beat_cnt == {1'b0, ar_len_q}));

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_idx <= winner;
        ar_addr_q <= req_araddr[winner * ADDR_W +: ADDR_W];
        ar_len_q  <= req_arlen[winner * LEN_W +: LEN_W];
        ar_id_q   <= ID_W'(ID_BASE + int'(winner));
        beat_cnt  <= '0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (mem_rlast) rr_ptr <= wrap_add(grant_idx, 1);
        if (proto_err) err <= 1'b1;
      end
    end
  end

  assign mem_araddr = ar_addr_q;
  assign mem_arlen  = ar_len_q;
  assign mem_arid   = ar_id_q;
  assign req_rdata  = mem_rdata;
  assign req_rlast  = mem_rlast;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sb_axi_arbiter.sv
// Directed bench for sb_axi_arbiter with a small memory-side responder and
// scoreboard queues holding expected AR requests and expected R beats.
module tb_sb_axi_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_arvalid;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*LW-1:0]  req_arlen;
  logic [NR-1:0]     req_arready;
  logic [NR-1:0]     req_rvalid;
  logic [DW-1:0]     req_rdata;
  logic              req_rlast;
  logic [NR-1:0]     req_rready;
  logic              mem_arvalid;
  logic              mem_arready;
  logic [AW-1:0]     mem_araddr;
  logic [LW-1:0]     mem_arlen;
  logic [IW-1:0]     mem_arid;
  logic              mem_rvalid;
  logic              mem_rready;
  logic [DW-1:0]     mem_rdata;
  logic              mem_rlast;
  logic [IW-1:0]     mem_rid;
  logic              busy;
  logic [1:0]        grant_idx;
  logic              err;

  always #5 clk = ~clk;

  sb_axi_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_BASE(0), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .req_rlast(req_rlast), .req_rready(req_rready),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arid(mem_arid),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .mem_rid(mem_rid),
    .busy(busy), .grant_idx(grant_idx), .err(err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IW-1:0] id;
  } ar_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_arvalid = '0;
    req_araddr  = '0;
    req_arlen   = '0;
    req_rready  = '0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rlast   = 1'b0;
    mem_rid     = '0;
  endtask

  task automatic set_req(input int rq, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_arvalid[rq]          = 1'b1;
    req_araddr[rq*AW +: AW]  = addr;
    req_arlen[rq*LW +: LW]   = len;
  endtask

  // Waits (bounded) for the accept pulse and records the AR the memory side should see
  task automatic wait_grant(input int rq, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int  n;
    ar_t e;
    n = 0;
    while (req_arready == '0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant_timeout", 64'(n < 20), 64'd1);
    chk("busy_at_grant", busy, 0);
    chk("arready_onehot", req_arready, 64'(1) << rq);
    e.addr = addr;
    e.len  = len;
    e.id   = IW'(rq);
    exp_ar.push_back(e);
  endtask

  // Entered one cycle after the grant, in ADDR; stalls mem_arready for stall cycles
  task automatic serve_ar(input int stall);
    ar_t e;
    e = '{default: '0};
    chk("ar_pending", exp_ar.size(), 1);
    if (exp_ar.size() > 0) e = exp_ar[0];
    for (int w = 0; w < stall; w++) begin
      mem_arready = 1'b0;
      chk("arvalid_held", mem_arvalid, 1);
      chk("araddr_stable", mem_araddr, e.addr);
      @(negedge clk); #1;
    end
    mem_arready = 1'b1;
    #1;
    chk("ar_valid", mem_arvalid, 1);
    chk("ar_addr", mem_araddr, e.addr);
    chk("ar_len", mem_arlen, e.len);
    chk("ar_id", mem_arid, e.id);
    if (exp_ar.size() > 0) void'(exp_ar.pop_front());
    @(negedge clk);
    mem_arready = 1'b0;
    #1;
    chk("ar_dropped", mem_arvalid, 0);
  endtask

  // Presents nbeats beats; last_at marks which beat carries RLAST (out of range = none)
  task automatic serve_data(input int rq, input int nbeats, input int last_at,
                            input logic bad_rid, input logic toggle);
    int            b, guard;
    logic          pending;
    logic [DW-1:0] d;
    beat_t         e, got;
    b = 0; guard = 0; pending = 1'b0; d = '0;
    while (b < nbeats && guard < 64) begin
      if (!pending) begin
        d      = $urandom;
        e.data = d;
        e.last = (b == last_at);
        exp_beat.push_back(e);
        pending = 1'b1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      mem_rlast  = (b == last_at);
      mem_rid    = bad_rid ? IW'(rq ^ 1) : IW'(rq);
      req_rready = '0;
      req_rready[rq] = toggle ? guard[0] : 1'b1;
      #1;
      chk("rvalid_steer", req_rvalid, 64'(1) << rq);
      chk("rready_mirror", mem_rready, req_rready[rq]);
      chk("no_grant_busy", req_arready, 0);
      if (req_rready[rq]) begin
        chk("beat_pending", exp_beat.size(), 1);
        got = '{default: '0};
        if (exp_beat.size() > 0) got = exp_beat.pop_front();
        chk("beat_data", req_rdata, got.data);
        chk("beat_last", req_rlast, got.last);
        pending = 1'b0;
        b++;
      end
      @(negedge clk);
      guard++;
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    req_rready = '0;
    #1;
    chk("beat_count", b, nbeats);
    if (last_at < nbeats) chk("idle_after_last", busy, 0);
  endtask

  task automatic run_burst(input int rq, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input int stall, input int nbeats, input int last_at,
                           input logic bad_rid, input logic toggle);
    set_req(rq, addr, len);
    #1;
    wait_grant(rq, addr, len);
    @(negedge clk);
    req_arvalid[rq] = 1'b0;
    #1;
    chk("grant_idx", grant_idx, rq);
    chk("ar_next_cycle", mem_arvalid, 1);
    serve_ar(stall);
    serve_data(rq, nbeats, last_at, bad_rid, toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_mem_arvalid", mem_arvalid, 0);
    chk("rst_mem_rready", mem_rready, 0);
    chk("rst_req_arready", req_arready, 0);
    chk("rst_req_rvalid", req_rvalid, 0);

    // Contention: all requesters held, rotation 0,1,2,3,0 with one-beat bursts
    for (int rq = 0; rq < NR; rq++) set_req(rq, AW'(32'h1000 + rq * 32'h40), 8'd0);
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % NR, AW'(32'h1000 + (k % NR) * 32'h40), 8'd0);
      @(negedge clk);
      if (k == 4) req_arvalid = '0;
      #1;
      chk("cont_grant_idx", grant_idx, k % NR);
      serve_ar(0);
      serve_data(k % NR, 1, 0, 1'b0, 1'b0);
    end
    chk("cont_err", err, 0);

    // Single request on requester 1
    run_burst(1, 32'h100, 8'd3, 0, 4, 3, 1'b0, 1'b0);
    chk("single_err", err, 0);

    // Backpressure: AR stalled 5 cycles, then toggling rready
    run_burst(3, 32'h2000, 8'd5, 5, 6, 5, 1'b0, 1'b1);
    chk("bp_err", err, 0);

    // Early RLAST on beat 2 of a len=3 burst
    run_burst(0, 32'h300, 8'd3, 0, 3, 2, 1'b0, 1'b0);
    chk("early_rlast_err", err, 1);
    chk("early_rlast_idle", busy, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_cleared", err, 0);

    // Wrong RID on a separate burst
    run_burst(2, 32'h400, 8'd1, 1, 2, 1, 1'b1, 1'b0);
    chk("bad_rid_err", err, 1);

    // Reset mid-DATA: rr_ptr was 3, so after reset requester 1 must beat requester 3
    set_req(2, 32'h500, 8'd3);
    #1;
    wait_grant(2, 32'h500, 8'd3);
    @(negedge clk);
    req_arvalid = '0;
    #1;
    serve_ar(0);
    serve_data(2, 2, 99, 1'b0, 1'b0);
    rst = 1'b1;
    exp_beat.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_arvalid", mem_arvalid, 0);
    chk("mid_rst_rvalid", req_rvalid, 0);
    chk("mid_rst_rready", mem_rready, 0);
    chk("mid_rst_grant_idx", grant_idx, 0);
    chk("mid_rst_err", err, 0);
    set_req(1, 32'h600, 8'd0);
    set_req(3, 32'h700, 8'd0);
    #1;
    wait_grant(1, 32'h600, 8'd0);
    @(negedge clk);
    req_arvalid = '0;
    #1;
    chk("post_rst_grant_idx", grant_idx, 1);
    serve_ar(0);
    serve_data(1, 1, 0, 1'b0, 1'b0);
    chk("post_rst_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
